// File: rtl/bram_fifo_ctrl_4096x4.sv
// FIFO controller for a 4096x4 dual-port BRAM; pop interface is first-word-fall-through.
// A two-entry output buffer hides the one-cycle BRAM read latency, which sustains one word per cycle.
module bram_fifo_ctrl_4096x4 #(
  parameter int AW = 12,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW:0]   count,
  output logic [AW-1:0] mem_a0,
  output logic [DW-1:0] mem_d0,
  output logic          mem_we0,
  output logic [DW-1:0] mem_wem0,
  output logic          mem_ce0,
  output logic [AW-1:0] mem_a1,
  output logic          mem_ce1,
  output logic          mem_we1,
  input  logic [DW-1:0] mem_q1
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   mem_count_q, mem_count_d;
  logic          rd_pend_q, rd_pend_d;
  logic [1:0]    occ_q, occ_d;
  logic [DW-1:0] buf0_q, buf0_d;
  logic [DW-1:0] buf1_q, buf1_d;
  logic          in_ready_q, in_ready_d;

  logic          push;
  logic          pop;
  logic          issue;
  logic [1:0]    occ_after_pop;

  always_comb begin
    push          = in_valid & in_ready_q;
    pop           = (occ_q != 2'd0) & out_ready;
    // Buffer plus in-flight read never exceeds two, so a pop frees a slot for this cycle's issue.
    issue         = (mem_count_q != '0) &
                    ((({1'b0, occ_q} + {2'b00, rd_pend_q}) < 3'd2) | pop);

    wr_ptr_d      = wr_ptr_q + {{(AW-1){1'b0}}, push};
    rd_ptr_d      = rd_ptr_q + {{(AW-1){1'b0}}, issue};
    mem_count_d   = mem_count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, issue};
    rd_pend_d     = issue;
    in_ready_d    = (mem_count_d != DEPTH);

    occ_after_pop = occ_q - {1'b0, pop};
    buf0_d        = pop ? buf1_q : buf0_q;
    buf1_d        = buf1_q;
    // Returning read data lands at the tail, measured after this cycle's pop.
    if (rd_pend_q) begin
      if (occ_after_pop == 2'd0) begin
        buf0_d = mem_q1;
      end else begin
        buf1_d = mem_q1;
      end
    end
    occ_d         = occ_after_pop + {1'b0, rd_pend_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
      rd_pend_q   <= 1'b0;
      occ_q       <= 2'd0;
      in_ready_q  <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      rd_pend_q   <= rd_pend_d;
      occ_q       <= occ_d;
      in_ready_q  <= in_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    buf0_q <= buf0_d;
    buf1_q <= buf1_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = buf0_q;
  assign count     = mem_count_q + {{AW{1'b0}}, rd_pend_q} + {{(AW-1){1'b0}}, occ_q};

  assign mem_a0    = wr_ptr_q;
  assign mem_d0    = in_data;
  assign mem_we0   = push;
  assign mem_ce0   = push;
  assign mem_wem0  = '1;
  assign mem_a1    = rd_ptr_q;
  assign mem_ce1   = issue;
  assign mem_we1   = 1'b0;

endmodule

// File: tb/tb_bram_fifo_ctrl_4096x4.sv
// Bench for bram_fifo_ctrl_4096x4: behavioural BRAM plus a queue scoreboard checked every cycle.
module tb_bram_fifo_ctrl_4096x4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic [12:0] count;
  logic [11:0] mem_a0;
  logic [3:0]  mem_d0;
  logic        mem_we0;
  logic [3:0]  mem_wem0;
  logic        mem_ce0;
  logic [11:0] mem_a1;
  logic        mem_ce1;
  logic        mem_we1;
  logic [3:0]  mem_q1;

  bram_fifo_ctrl_4096x4 dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count),
    .mem_a0(mem_a0), .mem_d0(mem_d0), .mem_we0(mem_we0), .mem_wem0(mem_wem0), .mem_ce0(mem_ce0),
    .mem_a1(mem_a1), .mem_ce1(mem_ce1), .mem_we1(mem_we1), .mem_q1(mem_q1)
  );

  always #5 clk = ~clk;

  logic [3:0] ram [4096];
  always @(posedge clk) begin
    if (mem_ce0 && mem_we0) ram[mem_a0] <= mem_d0;
    if (mem_ce1) mem_q1 <= ram[mem_a1];
  end

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] q[$];
  int wr_total, rd_issued;
  logic [3:0] last_pop;
  logic s_we0, s_ce1, s_ov, s_ir, did_push, did_pop;
  logic [11:0] s_a0, s_a1;
  logic [3:0] s_od;
  logic [12:0] s_cnt;

  // One clock: drive, sample at negedge, check against the queue, then commit the transfer.
  task automatic cycle(input logic iv, input logic [3:0] id, input logic ordy, input logic r);
    in_valid = iv; in_data = id; out_ready = ordy; rst = r;
    @(negedge clk);
    s_we0 = mem_we0; s_a0 = mem_a0; s_ce1 = mem_ce1; s_a1 = mem_a1;
    s_ov = out_valid; s_od = out_data; s_cnt = count; s_ir = in_ready;
    if (!r) begin
      vectors++;
      if (count !== 13'(q.size())) begin
        miscompares++;
        if (miscompares < 20) $display("FAIL count: got %0d expected %0d", count, q.size());
      end
      vectors++;
      if (out_valid === 1'b1 && q.size() == 0) begin
        miscompares++;
        if (miscompares < 20) $display("FAIL underflow: out_valid=1 expected 0 with empty model");
      end else if (out_valid === 1'b1 && out_data !== q[0]) begin
        miscompares++;
        if (miscompares < 20) $display("FAIL out_data: got %h expected %h", out_data, q[0]);
      end
      vectors++;
      if (mem_we1 !== 1'b0 || mem_wem0 !== 4'hF || mem_ce0 !== mem_we0) begin
        miscompares++;
        if (miscompares < 20) $display("FAIL port_consts: we1=%b wem0=%h ce0=%b expected 0/f/%b", mem_we1, mem_wem0, mem_ce0, mem_we0);
      end
      vectors++;
      if (mem_we0 !== (iv & in_ready)) begin
        miscompares++;
        if (miscompares < 20) $display("FAIL we0: got %b expected %b", mem_we0, iv & in_ready);
      end
      vectors++;
      if ((!in_ready && q.size() < 4096) || (in_ready && q.size() >= 4098)) begin
        miscompares++;
        if (miscompares < 20) $display("FAIL in_ready: got %b with depth %0d", in_ready, q.size());
      end
      if (mem_we0 === 1'b1) begin
        vectors++;
        if (mem_a0 !== 12'(wr_total) || mem_d0 !== id) begin
          miscompares++;
          if (miscompares < 20) $display("FAIL wr_port: a0=%0d d0=%h expected %0d %h", mem_a0, mem_d0, wr_total % 4096, id);
        end
      end
      if (mem_ce1 === 1'b1) begin
        vectors++;
        if (mem_a1 !== 12'(rd_issued) || rd_issued >= wr_total) begin
          miscompares++;
          if (miscompares < 20) $display("FAIL rd_port: a1=%0d expected %0d (written %0d)", mem_a1, rd_issued % 4096, wr_total);
        end
      end
    end
    did_push = iv & in_ready;
    did_pop  = out_valid & ordy;
    @(posedge clk); #1;
    if (r) begin
      q.delete(); wr_total = 0; rd_issued = 0;
    end else begin
      if (s_ce1) rd_issued++;
      if (did_pop && q.size() > 0) last_pop = q.pop_front();
      if (did_push) begin q.push_back(id); wr_total++; end
    end
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (q.size() > 0 && n < bound) begin cycle(1'b0, 4'h0, 1'b1, 1'b0); n++; end
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d words left expected 0", q.size());
    end
  endtask

  task automatic test_reset;
    cycle(1'b0, 4'h0, 1'b0, 1'b1);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    vectors++;
    if (s_ov !== 1'b0 || s_cnt !== 13'd0 || s_ir !== 1'b1 || s_we0 !== 1'b0 || s_ce1 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: ov=%b cnt=%0d ir=%b we0=%b ce1=%b expected 0 0 1 0 0", s_ov, s_cnt, s_ir, s_we0, s_ce1);
    end
  endtask

  task automatic test_single;
    test_reset();
    cycle(1'b1, 4'hA, 1'b1, 1'b0);
    vectors++;
    if (s_we0 !== 1'b1 || s_a0 !== 12'd0) begin
      miscompares++; $display("FAIL single_c0: we0=%b a0=%0d expected 1 0", s_we0, s_a0);
    end
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    vectors++;
    if (s_ce1 !== 1'b1 || s_a1 !== 12'd0 || s_cnt !== 13'd1) begin
      miscompares++; $display("FAIL single_c1: ce1=%b a1=%0d cnt=%0d expected 1 0 1", s_ce1, s_a1, s_cnt);
    end
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    vectors++;
    if (s_ov !== 1'b0 || s_cnt !== 13'd1) begin
      miscompares++; $display("FAIL single_c2: ov=%b cnt=%0d expected 0 1", s_ov, s_cnt);
    end
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    vectors++;
    if (s_ov !== 1'b1 || s_od !== 4'hA || s_cnt !== 13'd1) begin
      miscompares++; $display("FAIL single_c3: ov=%b data=%h cnt=%0d expected 1 a 1", s_ov, s_od, s_cnt);
    end
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    vectors++;
    if (s_ov !== 1'b0 || s_cnt !== 13'd0) begin
      miscompares++; $display("FAIL single_c4: ov=%b cnt=%0d expected 0 0", s_ov, s_cnt);
    end
  endtask

  task automatic test_stream;
    int pushed = 0;
    int cyc = 0;
    test_reset();
    while (pushed < 10000 && cyc < 12000) begin
      cycle(1'b1, 4'(pushed), 1'b1, 1'b0);
      if (did_push) pushed++;
      if (cyc >= 3) begin
        vectors++;
        if (s_ov !== 1'b1 || s_ir !== 1'b1) begin
          miscompares++;
          if (miscompares < 20) $display("FAIL stream_rate: cycle %0d ov=%b ir=%b expected 1 1", cyc, s_ov, s_ir);
        end
      end
      cyc++;
    end
    vectors++;
    if (pushed != 10000) begin
      miscompares++; $display("FAIL stream_pushes: got %0d expected 10000", pushed);
    end
    drain(20);
  endtask

  task automatic test_full;
    int pushed = 0;
    int cyc = 0;
    test_reset();
    s_ir = 1'b1;
    while (s_ir && cyc < 5000) begin
      cycle(1'b1, 4'(pushed), 1'b0, 1'b0);
      if (did_push) pushed++;
      cyc++;
    end
    vectors++;
    if (pushed != 4098 || s_cnt !== 13'd4098) begin
      miscompares++; $display("FAIL full_capacity: accepted %0d count %0d expected 4098 4098", pushed, s_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 4'hF, 1'b0, 1'b0);
      vectors++;
      if (s_we0 !== 1'b0) begin
        miscompares++; $display("FAIL full_ignore: we0=%b expected 0", s_we0);
      end
    end
    cycle(1'b1, 4'hC, 1'b1, 1'b0);
    vectors++;
    if (s_ir !== 1'b0 || did_pop !== 1'b1 || did_push !== 1'b0) begin
      miscompares++; $display("FAIL full_pushpop: ir=%b pop=%b push=%b expected 0 1 0", s_ir, did_pop, did_push);
    end
    cycle(1'b1, 4'hC, 1'b0, 1'b0);
    vectors++;
    if (s_ir !== 1'b1 || did_push !== 1'b1) begin
      miscompares++; $display("FAIL full_reopen: ir=%b push=%b expected 1 1", s_ir, did_push);
    end
    drain(5000);
    vectors++;
    if (last_pop !== 4'hC) begin
      miscompares++; $display("FAIL full_order: last word %h expected c", last_pop);
    end
  endtask

  task automatic test_random;
    test_reset();
    for (int i = 0; i < 20000; i++)
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
    drain(5000);
  endtask

  task automatic test_reset_inflight;
    int n = 0;
    test_reset();
    cycle(1'b1, 4'h1, 1'b0, 1'b0);
    cycle(1'b1, 4'h2, 1'b0, 1'b0);
    cycle(1'b1, 4'h3, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b1);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    vectors++;
    if (s_ov !== 1'b0 || s_cnt !== 13'd0 || s_ir !== 1'b1) begin
      miscompares++; $display("FAIL midreset: ov=%b cnt=%0d ir=%b expected 0 0 1", s_ov, s_cnt, s_ir);
    end
    cycle(1'b1, 4'h5, 1'b1, 1'b0);
    s_ov = 1'b0;
    while (!s_ov && n < 10) begin cycle(1'b0, 4'h0, 1'b1, 1'b0); n++; end
    vectors++;
    if (s_ov !== 1'b1 || s_od !== 4'h5) begin
      miscompares++; $display("FAIL midreset_first: ov=%b data=%h expected 1 5", s_ov, s_od);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0;
    wr_total = 0; rd_issued = 0; last_pop = 4'h0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_stream();
    test_full();
    test_reset_inflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
